icache_loader: RTL and testbench
================================

# icache_loader

Boot-time program loader for one mesh tile. Accepts a framed instruction stream over a valid/ready port, writes it into the tile's instruction cache through the cache's write port, and holds the tile core in reset until the program is fully written. Sits beside the tile: its `icache_*` outputs drive the tile's cache programming inputs, and `core_hold` gates the core's reset. A `reload` request returns the tile to programming mode at any time.

## Interface
- `ADDR_W`, default 8: icache address width; the cache has 2^ADDR_W entries.
- `INSTR_W`, default 32: instruction width. Must satisfy INSTR_W >= 2*ADDR_W.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  INSTR_W  stream word (header or instruction).
- `in_ready`  out  1  loader can accept a word this cycle.
- `reload`  in  1  return to programming mode (level, sampled each cycle).
- `icache_write`  out  1  icache write strobe, one cycle per word.
- `icache_addr`  out  ADDR_W  icache write address.
- `icache_data`  out  INSTR_W  icache write data.
- `core_hold`  out  1  1 = tile core held in reset.
- `load_done`  out  1  one-cycle pulse when the core is released.

## Operation
- Transfer: a word is accepted on a rising edge where `in_valid && in_ready`. The loader never backpressures mid-frame. `in_ready = 1` in IDLE and LOAD, 0 in DRAIN and RUN, and is forced to 0 while `rst` is high.
- Frame: header word, then N instruction words.
  - Header `in_data[ADDR_W-1:0]` = start address S.
  - Header `in_data[2*ADDR_W-1:ADDR_W]` = N-1, so N ranges from 1 to 2^ADDR_W.
  - Upper header bits are ignored.
- States:
  - IDLE: `core_hold` = 1. Waits for the header. Accepting the header latches S into the write pointer and N-1 into the remaining counter, then moves to LOAD.
  - LOAD: each accepted word is registered to `icache_data`, with `icache_addr` = pointer and `icache_write` = 1 on the following cycle. The pointer then increments modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0). The counter decrements. Accepting the word with counter = 0 moves to DRAIN.
  - DRAIN: exactly one cycle, in which the final write strobe is presented. Next state is RUN.
  - RUN: `core_hold` = 0. Accepts nothing.
- `load_done` is high for the first cycle of RUN only.
- `reload` = 1 in any state moves to IDLE on the next edge, with `core_hold` = 1 from that edge.
  - In LOAD or DRAIN this aborts the frame. A write strobe already registered still completes on the cycle after the abort edge. Words already written are not erased.
  - `reload` held high keeps the loader in IDLE, and a header is not accepted while `reload` = 1.
- Writes with no `in_valid` gap occur every cycle. Gaps in `in_valid` only stretch LOAD.

## Timing
- Reset values: state IDLE, `core_hold` = 1, `icache_write` = 0, `icache_addr` = 0, `icache_data` = 0, `load_done` = 0, `in_ready` = 0 while `rst` is asserted.
- Write latency: a word accepted at edge k appears as `icache_write` = 1 with its address and data in the cycle after edge k. The cache captures it at edge k+1.
- Release latency: with the last word accepted at edge k, the last write strobe is presented in cycle k→k+1 (DRAIN). `core_hold` falls and `load_done` rises at edge k+1, so the core never fetches before the last write lands.
- Back-to-back frames are not possible; a new frame requires `reload` first.
- `rst` mid-frame: immediate return to reset values; a partial program stays in the cache.
- `icache_write` is never high in IDLE except for the single trailing strobe after an abort, and never high in RUN.

## Test plan
- Basic load, `ADDR_W` = 8:
  - Stimulus: header S = 0x10, N-1 = 2, then words A, B, C with `in_valid` held high.
  - Required response: writes (0x10,A), (0x11,B), (0x12,C) on three consecutive cycles. `core_hold` falls one edge after C is accepted, and `load_done` pulses once.
- Wrap-around:
  - Stimulus: S = 0xFE, N-1 = 3.
  - Required response: addresses 0xFE, 0xFF, 0x00, 0x01 in order.
- Full depth and single word:
  - Stimulus: N-1 = 0xFF (256 words) from S = 0, then a separate frame with N-1 = 0.
  - Required response: the first frame writes all 256 entries. The second frame writes exactly one word and releases the core.
- Bubbles:
  - Stimulus: randomised `in_valid` gaps during LOAD.
  - Required response: `in_ready` stays 1, writes occur only for accepted words with contiguous addresses, and `core_hold` stays 1 until the final write.
- Reload in RUN and mid-frame:
  - Stimulus: `reload` pulsed in RUN, then a new header, then `reload` asserted after 2 of 5 words.
  - Required response: `core_hold` rises at the next edge each time. Exactly 2 writes plus no further writes occur, and the loader is back in IDLE accepting a new header.
- Async reset mid-LOAD:
  - Stimulus: assert `rst` between clock edges.
  - Required response: all outputs take reset values immediately without waiting for a clock edge, and `core_hold` = 1.

Source files
------------

// File: rtl/icache_loader.sv
// Boot loader: streams a framed program into the tile icache, holding the core in reset until done.
// Latency: accepted word written one cycle later; core released one edge after the last write strobe.
// Backpressure: never stalls mid-frame; in_ready is low only in DRAIN/RUN and during reset.
module icache_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  input  logic               reload,
  output logic               icache_write,
  output logic [ADDR_W-1:0]  icache_addr,
  output logic [INSTR_W-1:0] icache_data,
  output logic               core_hold,
  output logic               load_done
);

  // The header must carry both the start address and the count.
  if (INSTR_W < 2 * ADDR_W) begin : g_bad_width
    $error("icache_loader: INSTR_W must be >= 2*ADDR_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              take_hdr;
  logic              take_word;

  // Ready is combinational on rst so it drops the instant reset asserts.
  assign in_ready  = !rst && ((state == IDLE) || (state == LOAD));
  assign accept    = in_valid && in_ready;
  // A header offered while reload is high is ignored so reload keeps us parked in IDLE.
  assign take_hdr  = accept && (state == IDLE) && !reload;
  // A word accepted on the abort edge is still written (the single trailing strobe).
  assign take_word = accept && (state == LOAD);
  // The core runs only in RUN; everything else keeps it in reset.
  assign core_hold = (state != RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; reload overrides every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_hdr) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (reload) begin
          state_nxt = IDLE;
        end else if (take_word && (cnt == '0)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = reload ? IDLE : RUN;
      end
      RUN: begin
        if (reload) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write pointer / remaining count, and the registered icache write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      cnt          <= '0;
      icache_write <= 1'b0;
      icache_addr  <= '0;
      icache_data  <= '0;
    end else begin
      icache_write <= take_word;
      if (take_hdr) begin
        ptr <= in_data[ADDR_W-1:0];
        cnt <= in_data[2*ADDR_W-1:ADDR_W];
      end else if (take_word) begin
        icache_addr <= ptr;
        icache_data <= in_data;
        ptr         <= ptr + ADDR_W'(1);
        cnt         <= cnt - ADDR_W'(1);
      end
    end
  end

  // One-cycle release pulse coinciding with the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done <= 1'b0;
    end else begin
      load_done <= (state == DRAIN) && !reload;
    end
  end

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader: frame loads, wrap, full depth, bubbles, reload and async reset.
// Inputs driven 1ns after the rising edge; outputs sampled there or on the falling edge.
// Write strobes are logged by a falling-edge monitor and compared against hand-computed frames.
module tb_icache_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        reload;
  logic        icache_write;
  logic [7:0]  icache_addr;
  logic [31:0] icache_data;
  logic        core_hold;
  logic        load_done;

  icache_loader #(.ADDR_W(8), .INSTR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .icache_write (icache_write),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .core_hold    (core_hold),
    .load_done    (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int bub_bad = 0;
  int wr_in_run = 0;

  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe presented to the cache.
  always @(negedge clk) begin
    if (!rst && icache_write) begin
      wq_addr.push_back(icache_addr);
      wq_data.push_back(icache_data);
      wq_cyc.push_back(cyc);
      if (!core_hold) wr_in_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Header then nw words (base+i); optional random idle gaps before each word.
  task automatic send_frame(input logic [7:0] s, input logic [7:0] nm1, input int nw,
                            input bit gaps, input logic [31:0] base);
    acc_q.delete();
    in_valid = 1'b1;
    in_data  = {16'hBEEF, nm1, s};
    step();
    for (int i = 0; i < nw; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          in_data  = 32'h0;
          step();
          if (!in_ready || !core_hold) bub_bad++;
        end
      end
      in_valid = 1'b1;
      in_data  = base + i;
      step();
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  // Called 1ns after the last word's accept edge (DRAIN cycle).
  task automatic check_release(input string tag);
    chk({tag, "_hold_drain"}, core_hold, 1'b1);
    chk({tag, "_rdy_drain"}, in_ready, 1'b0);
    step();
    chk({tag, "_hold_run"}, core_hold, 1'b0);
    chk({tag, "_done_pulse"}, load_done, 1'b1);
    chk({tag, "_rdy_run"}, in_ready, 1'b0);
    step();
    chk({tag, "_done_once"}, load_done, 1'b0);
    chk({tag, "_hold_stays"}, core_hold, 1'b0);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] s, input int n,
                              input logic [31:0] base);
    int bad;
    bad = 0;
    chk({tag, "_nwrites"}, wq_addr.size(), n);
    if (wq_addr.size() == n && acc_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] ea;
        ea = s + 8'(i);
        if (wq_addr[i] !== ea || wq_data[i] !== base + i || wq_cyc[i] != acc_q[i]) bad++;
      end
    end else begin
      bad = 1;
    end
    chk({tag, "_bad_entries"}, bad, 0);
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    step();
    chk({tag, "_hold_after_reload"}, core_hold, 1'b1);
    reload = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    reload   = 1'b0;
    #3;
    chk("rst_hold", core_hold, 1'b1);
    chk("rst_write", icache_write, 1'b0);
    chk("rst_addr", icache_addr, 8'h00);
    chk("rst_data", icache_data, 32'h0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    #19;
    rst = 1'b0;
    step();
    chk("idle_ready", in_ready, 1'b1);

    // Basic load: S=0x10, 3 words.
    send_frame(8'h10, 8'd2, 3, 1'b0, 32'hA000_0000);
    check_release("basic");
    check_writes("basic", 8'h10, 3, 32'hA000_0000);

    // Reload in RUN, with a header offered while reload is high (must be ignored).
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = {16'h0, 8'd0, 8'h77};
    step();
    chk("run_reload_hold", core_hold, 1'b1);
    step();
    reload   = 1'b0;
    in_valid = 1'b0;
    step();

    // Wrap-around: S=0xFE, 4 words.
    send_frame(8'hFE, 8'd3, 4, 1'b0, 32'hB000_0000);
    check_release("wrap");
    check_writes("wrap", 8'hFE, 4, 32'hB000_0000);
    pulse_reload("wrap");

    // Full depth: 256 words from 0.
    send_frame(8'h00, 8'hFF, 256, 1'b0, 32'hC000_0000);
    check_release("full");
    check_writes("full", 8'h00, 256, 32'hC000_0000);
    pulse_reload("full");

    // Single word.
    send_frame(8'h40, 8'h00, 1, 1'b0, 32'hD000_0000);
    check_release("single");
    check_writes("single", 8'h40, 1, 32'hD000_0000);
    pulse_reload("single");

    // Bubbles in LOAD.
    send_frame(8'h80, 8'd5, 6, 1'b1, 32'hE000_0000);
    check_release("bubble");
    check_writes("bubble", 8'h80, 6, 32'hE000_0000);
    chk("bubble_ready_hold", bub_bad, 0);
    pulse_reload("bubble");

    // Mid-frame abort after 2 of 5 words.
    send_frame(8'h20, 8'd4, 2, 1'b0, 32'hF000_0000);
    reload = 1'b1;
    step();
    chk("abort_hold", core_hold, 1'b1);
    in_valid = 1'b1;
    in_data  = {16'h0, 8'd0, 8'h99};
    step();
    step();
    reload   = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    chk("abort_hold_idle", core_hold, 1'b1);
    chk("abort_ready_idle", in_ready, 1'b1);
    check_writes("abort", 8'h20, 2, 32'hF000_0000);

    // Loader accepts a fresh header after the abort.
    send_frame(8'h30, 8'h00, 1, 1'b0, 32'h1234_0000);
    check_release("post_abort");
    check_writes("post_abort", 8'h30, 1, 32'h1234_0000);
    pulse_reload("post_abort");

    // Async reset mid-LOAD, asserted between edges while a strobe is active.
    send_frame(8'h50, 8'd7, 3, 1'b0, 32'h5500_0000);
    chk("pre_arst_write", icache_write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_write", icache_write, 1'b0);
    chk("arst_addr", icache_addr, 8'h00);
    chk("arst_data", icache_data, 32'h0);
    chk("arst_hold", core_hold, 1'b1);
    chk("arst_done", load_done, 1'b0);
    chk("arst_ready", in_ready, 1'b0);
    #10;
    rst = 1'b0;
    step();

    chk("no_write_in_run", wr_in_run, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
